// File: rtl/ad9833_freq_writer_if.sv
// Handshake and pin bundle for the AD9833 frequency writer.
// master drives the request side; slave is the serializer.
interface ad9833_freq_writer_if;
    logic        go;
    logic [15:0] control;
    logic [27:0] freq;
    logic        good_to_reset_go;
    logic        send_complete;
    logic        busy;
    logic        fsync;
    logic        sclk;
    logic        sdata;

    modport master (
        output go, control, freq,
        input  good_to_reset_go, send_complete, busy, fsync, sclk, sdata
    );

    modport slave (
        input  go, control, freq,
        output good_to_reset_go, send_complete, busy, fsync, sclk, sdata
    );
endinterface

// File: rtl/ad9833_freq_writer.sv
// Serializes control + 28-bit frequency into three 16-bit AD9833 words on FSYNC/SCLK/SDATA.
// Latency 3*(33*SCLK_DIV+FSYNC_GAP) cycles from acceptance to send_complete; go ignored while busy.
module ad9833_freq_writer #(
    parameter int SCLK_DIV  = 25,
    parameter int FSYNC_GAP = 10,
    parameter int FREQ_REG  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    ad9833_freq_writer_if.slave   bus
);

    localparam int MAXC = (SCLK_DIV > FSYNC_GAP) ? SCLK_DIV : FSYNC_GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(FSYNC_GAP - 1);
    localparam logic [1:0]    PREFIX   = (FREQ_REG == 0) ? 2'b01 : 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LO, S_HI, S_GAP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q;
    logic            ack_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [1:0]      word_cnt_q;
    logic [15:0]     shift_q;
    logic [15:0]     w1_q;
    logic [15:0]     w2_q;
    logic            accept;

    logic            fsync_c, sclk_c, sdata_c, busy_c, done_c;

    // Bits 15:13 of control are replaced by the address/B28 bits.
    logic unused_ctl;
    assign unused_ctl = ^bus.control[15:13];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.go && armed_q) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: if (cnt_q == DIV_LAST) state_d = S_LO;
            S_LO:    if (cnt_q == DIV_LAST) state_d = S_HI;
            S_HI: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = (bit_cnt_q == 4'd15) ? S_GAP : S_LO;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = (word_cnt_q == 2'd2) ? S_DONE : S_SETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fsync_c = 1'b1;
        sclk_c  = 1'b1;
        sdata_c = 1'b0;
        busy_c  = (state_q != S_IDLE);
        done_c  = (state_q == S_DONE);
        case (state_q)
            S_SETUP, S_HI: begin
                fsync_c = 1'b0;
                sdata_c = shift_q[15];
            end
            S_LO: begin
                fsync_c = 1'b0;
                sclk_c  = 1'b0;
                sdata_c = shift_q[15];
            end
            default: ;
        endcase
    end

    assign bus.fsync            = fsync_c;
    assign bus.sclk             = sclk_c;
    assign bus.sdata            = sdata_c;
    assign bus.busy             = busy_c;
    assign bus.send_complete    = done_c;
    assign bus.good_to_reset_go = ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
        end else begin
            ack_q <= accept;
            // Re-arm only after go has been seen low, so a held go cannot retrigger.
            if (!bus.go) begin
                armed_q <= 1'b1;
            end else if (accept) begin
                armed_q <= 1'b0;
            end

            if (state_d != state_q || state_q == S_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (accept) begin
                shift_q    <= {2'b00, 1'b1, bus.control[12:0]};
                w1_q       <= {PREFIX, bus.freq[13:0]};
                w2_q       <= {PREFIX, bus.freq[27:14]};
                word_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else if (state_q == S_LO && state_d == S_HI) begin
                // Last HI phase is FSYNC hold: keep the LSB on the pin.
                if (bit_cnt_q != 4'd15) begin
                    shift_q <= {shift_q[14:0], 1'b0};
                end
            end else if (state_q == S_HI && state_d == S_LO) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (state_q == S_GAP && state_d == S_SETUP) begin
                shift_q    <= w1_q;
                w1_q       <= w2_q;
                word_cnt_q <= word_cnt_q + 2'd1;
                bit_cnt_q  <= '0;
            end
        end
    end

endmodule
